// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

   localparam int unsigned PTR_W    = 4;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned FILT_LEN = 3;
   localparam int unsigned CNT_W    = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WRITE,
      S_WRITE_ACK,
      S_READ,
      S_READ_ACK,
      S_IGNORE
   } state_t;

   // Majority vote over the glitch-filter window
   function automatic logic majority(input logic [FILT_LEN-1:0] v);
      int unsigned ones;
      ones = 0;
      for (int unsigned i = 0; i < FILT_LEN; i++) begin
         if (v[i]) ones++;
      end
      return (ones > (FILT_LEN / 2));
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line conditioner: 2-FF synchroniser, majority glitch filter and
// rise/fall detection on the filtered level.
module i2c_line_sync
   import i2c_target_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0]          r_sync;
   logic [FILT_LEN-2:0] r_hist;
   logic                r_filt;
   logic                r_filt_d;
   logic [FILT_LEN-1:0] w_window;

   // Window is the newest synchronised sample plus the history behind it
   assign w_window = {r_hist, r_sync[1]};

   // Synchronise, filter and delay the line; idle bus level is high
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync   <= '1;
         r_hist   <= '1;
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
      end else begin
         r_sync   <= {r_sync[0], i_line};
         r_hist   <= w_window[FILT_LEN-2:0];
         r_filt   <= majority(w_window);
         r_filt_d <= r_filt;
      end
   end

   assign o_level = r_filt;
   assign o_rise  = r_filt & ~r_filt_d;
   assign o_fall  = ~r_filt & r_filt_d;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16 x 8-bit register file at DEV_ADDR, with a local
// host port onto the same registers.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR  = 7'h3C,
   parameter int unsigned REG_COUNT = 16
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_sda_in,
   input  logic              i_scl_in,
   output logic              o_sda_oe,
   output logic              o_scl_oe,
   input  logic [PTR_W-1:0]  i_host_addr,
   output logic [BYTE_W-1:0] o_host_rdata,
   input  logic              i_host_we,
   input  logic [BYTE_W-1:0] i_host_wdata,
   output logic              o_wr_valid,
   output logic [PTR_W-1:0]  o_wr_addr,
   output logic [BYTE_W-1:0] o_wr_data,
   output logic              o_busy
);

   state_t              r_state;
   logic [CNT_W-1:0]    r_bitcnt;
   logic [BYTE_W-2:0]   r_shift;
   logic [PTR_W-1:0]    r_ptr;
   logic                r_nine;
   logic                r_sda_oe;
   logic                r_busy;
   logic                r_wr_valid;
   logic [PTR_W-1:0]    r_wr_addr;
   logic [BYTE_W-1:0]   r_wr_data;
   logic [BYTE_W-1:0]   r_regs [REG_COUNT];

   logic                w_scl_level;
   logic                w_scl_rise;
   logic                w_scl_fall;
   logic                w_sda_level;
   logic                w_sda_rise;
   logic                w_sda_fall;
   logic                w_start;
   logic                w_stop;
   logic                w_last_bit;
   logic                w_commit;
   logic [BYTE_W-1:0]   w_byte_in;

   i2c_line_sync u_scl_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_scl_in),
      .o_level (w_scl_level),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_sda_in),
      .o_level (w_sda_level),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   assign w_start    = w_scl_level & w_sda_fall;
   assign w_stop     = w_scl_level & w_sda_rise;
   assign w_last_bit = (r_bitcnt == CNT_W'(BYTE_W - 1));
   assign w_byte_in  = {r_shift, w_sda_level};
   assign w_commit   = (r_state == S_WRITE) & w_scl_rise & w_last_bit & ~w_start & ~w_stop;

   // Bus protocol FSM: framing, ACK/data drive on SCL fall, pointer and commit strobe
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_nine     <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_valid <= 1'b0;
         if (w_start) begin
            r_state  <= S_ADDR;
            r_bitcnt <= '0;
            r_nine   <= 1'b0;
            r_sda_oe <= 1'b0;
         end else if (w_stop) begin
            r_state  <= S_IDLE;
            r_nine   <= 1'b0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR, S_PTR, S_WRITE: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte_in[BYTE_W-2:0];
                     r_bitcnt <= r_bitcnt + CNT_W'(1);
                     if (w_last_bit) begin
                        r_nine <= 1'b0;
                        if (r_state == S_ADDR) begin
                           if (w_byte_in[7:1] == DEV_ADDR) begin
                              r_busy  <= 1'b1;
                              r_state <= S_ADDR_ACK;
                           end else begin
                              r_busy  <= 1'b0;
                              r_state <= S_IGNORE;
                           end
                        end else if (r_state == S_PTR) begin
                           r_ptr   <= w_byte_in[PTR_W-1:0];
                           r_state <= S_PTR_ACK;
                        end else begin
                           r_wr_valid <= 1'b1;
                           r_wr_addr  <= r_ptr;
                           r_wr_data  <= w_byte_in;
                           r_ptr      <= r_ptr + PTR_W'(1);
                           r_state    <= S_WRITE_ACK;
                        end
                     end
                  end
               end

               // First fall drives ACK, 9th rise arms, following fall ends the slot
               S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_nine) begin
                        r_sda_oe <= 1'b1;
                     end else begin
                        r_nine   <= 1'b0;
                        r_bitcnt <= '0;
                        if ((r_state == S_ADDR_ACK) && r_shift[0]) begin
                           r_state  <= S_READ;
                           r_shift  <= r_regs[r_ptr][BYTE_W-2:0];
                           r_sda_oe <= ~r_regs[r_ptr][BYTE_W-1];
                        end else begin
                           r_sda_oe <= 1'b0;
                           r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WRITE;
                        end
                     end
                  end else if (w_scl_rise) begin
                     r_nine <= 1'b1;
                  end
               end

               S_READ: begin
                  if (w_scl_fall) begin
                     r_sda_oe <= ~r_shift[BYTE_W-2];
                     r_shift  <= {r_shift[BYTE_W-3:0], 1'b0};
                  end else if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + CNT_W'(1);
                     if (w_last_bit) begin
                        r_nine  <= 1'b0;
                        r_state <= S_READ_ACK;
                     end
                  end
               end

               // NACK is decided on the 9th rise; ACK reloads on the closing fall
               S_READ_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_nine) begin
                        r_sda_oe <= 1'b0;
                     end else begin
                        r_nine   <= 1'b0;
                        r_bitcnt <= '0;
                        r_state  <= S_READ;
                        r_shift  <= r_regs[r_ptr][BYTE_W-2:0];
                        r_sda_oe <= ~r_regs[r_ptr][BYTE_W-1];
                     end
                  end else if (w_scl_rise) begin
                     if (!w_sda_level) begin
                        r_nine <= 1'b1;
                        r_ptr  <= r_ptr + PTR_W'(1);
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end

               default: begin
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   // Register file: bus commit is applied after the host write so it wins a same-index collision
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (i_host_we) r_regs[i_host_addr] <= i_host_wdata;
         if (w_commit)  r_regs[r_ptr]       <= w_byte_in;
      end
   end

   assign o_host_rdata = r_regs[i_host_addr];
   assign o_sda_oe     = r_sda_oe;
   assign o_scl_oe     = 1'b0;
   assign o_wr_valid   = r_wr_valid;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_busy       = r_busy;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) that answers the camera-control I2C master on the same open-drain bus pair. Exposes a 16 × 8-bit register file to the bus at a parameterised 7-bit address, with a local host port for reading and writing the same registers. Used as an on-chip loopback target for bringing up and regressing the master, and as a configuration endpoint for soft peripherals.

## Interface
- `DEV_ADDR`, default 7'h3C: 7-bit target address this block answers.
- `REG_COUNT`, default 16: register count; fixed at 16 (pointer 4 bits).
- `clk` in 1: system clock; must be ≥ 20× SCL frequency.
- `reset` in 1: reset, asynchronous and active-high.
- `sda_in` in 1: bus SDA level, asynchronous.
- `scl_in` in 1: bus SCL level, asynchronous.
- `sda_oe` out 1: 1 pulls SDA low; 0 releases it.
- `scl_oe` out 1: SCL pull-down; tied 0 (no clock stretching).
- `host_addr` in 4: host read/write register index.
- `host_rdata` out 8: combinational read of `regs[host_addr]`.
- `host_we` in 1: host write strobe.
- `host_wdata` in 8: host write data.
- `wr_valid` out 1: one-cycle pulse when a bus data byte is committed.
- `wr_addr` out 4: register index of the committed byte.
- `wr_data` out 8: committed byte.
- `busy` out 1: high from an address-matched START until STOP or a non-matching repeated START.

## Operation
- `scl_in` and `sda_in` each pass through a 2-FF synchroniser, then a 3-sample majority glitch filter. Edges are detected on the filtered levels.
- START: filtered SDA falls while SCL is high. STOP: SDA rises while SCL is high. Either event is honoured in every state, and START also acts as a repeated START.
- FSM states: IDLE → ADDR (8 bits, MSB first, sampled on SCL rise) → ADDR_ACK.
  - Address match, R/W=0: go to PTR.
  - Address match, R/W=1: go to READ.
  - Mismatch: go to IGNORE, with no ACK driven.
- PTR → PTR_ACK: low 4 bits of the byte load the pointer; upper bits are ignored. Then WRITE.
- WRITE → WRITE_ACK: store the byte in `regs[ptr]`, pulse `wr_valid`, increment the pointer (15 wraps to 0), and return to WRITE.
- READ: output `regs[ptr]` MSB first, then READ_ACK, where SDA is sampled on SCL rise.
  - Master ACK (0): increment the pointer and go to READ.
  - Master NACK (1): go to IGNORE.
- IGNORE: hold `sda_oe` = 0 until START or STOP.
- STOP returns the FSM to IDLE. The pointer persists across transactions, so a repeated-START read continues from the last written pointer.
- ACK is driven by setting `sda_oe` = 1 for the whole 9th SCL-low period.
- The bit counter clears on every START.
- Collision: a host write and a bus write to the same register in the same cycle resolve with the bus write winning. A host write to a different register in that cycle also completes.

## Timing
- Reset values: `sda_oe` = 0, `scl_oe` = 0, `wr_valid` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, FSM = IDLE, pointer = 0, all `regs` = 8'h00.
- Pin-to-detected-edge latency is 4 clk (2 for the synchroniser, 2 for the filter).
- `sda_oe` updates on the clk after a detected SCL fall. Data and ACK changes therefore land within SCL low, and are released on the SCL fall that ends the ACK or bit slot.
- `wr_valid` pulses for exactly 1 clk, on the cycle after the SCL rise that samples the 8th data bit. `wr_addr` and `wr_data` hold until the next commit.
- `host_rdata` has 0-cycle latency. A host write is visible on the next clk.
- Reset mid-transaction releases SDA immediately (asynchronously) and returns the FSM to IDLE. The master then sees a NACK or arbitration loss.

## Structure
- Package `i2c_target_pkg` holds:
  - the FSM state enum;
  - `PTR_W` = 4 and `BYTE_W` = 8;
  - `FILT_LEN` = 3.
- Sub-module `i2c_line_sync` contains the synchroniser, glitch filter and rise/fall edge detector. It is instantiated once for SCL and once for SDA.
- The top level contains the FSM, shift register, bit counter, pointer and register file.

## Test plan
- Write 0x3C/W, ptr 0x02, data 0xA5, 0x5A, then STOP:
  - ACK is driven on all 4 bytes.
  - `regs[2]` = 0xA5 and `regs[3]` = 0x5A.
  - `wr_valid` pulses twice, with `wr_addr` = 2 then 3.
- Write ptr 0x0F, then repeated START 0x3C/R and read 2 bytes (ACK, then NACK). Using the preset 0x11 at reg 15 and 0x22 at reg 0, the bytes read are 0x11 then 0x22 (the pointer wraps).
- Address 0x3D/W: `sda_oe` stays 0 through the 9th clock, `busy` stays 0, and no register changes.
- A 1-clk SDA glitch while SCL is high inside a data byte produces no START or STOP detection and leaves the byte intact.
- A host write of 0x77 to reg 4 in the same clk as a bus commit of 0x99 to reg 4 leaves `regs[4]` = 0x99.
- Assert `reset` after the 4th data bit of a write: `sda_oe` = 0 immediately, the register is unchanged, and the next transaction completes normally.
